// File: rtl/lob_pkg.sv
// Shared types and constants for the limit-order-book query engine.
// Contents: side encodings, order-table entry struct, FSM state enum,
// the power-on DEFAULT_BOOK contents and a helper returning the preload
// value for any table index (entries past the default list are invalid).
package lob_pkg;

  localparam int LOB_W = 16;

  localparam logic SIDE_BID = 1'b0;
  localparam logic SIDE_ASK = 1'b1;

  typedef struct packed {
    logic             valid;
    logic             side;
    logic [LOB_W-1:0] size;
    logic [LOB_W-1:0] limit;
  } order_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FINISH
  } state_t;

  localparam int DEFAULT_N = 4;

  localparam order_entry_t DEFAULT_BOOK [DEFAULT_N] = '{
    '{1'b1, SIDE_BID, 16'd1,  16'd1},
    '{1'b1, SIDE_BID, 16'd4,  16'd1},
    '{1'b1, SIDE_ASK, 16'd7,  16'd1},
    '{1'b1, SIDE_BID, 16'd10, 16'd2}
  };

  function automatic order_entry_t default_entry(int unsigned i);
    if (i < DEFAULT_N) return DEFAULT_BOOK[i[1:0]];
    return '0;
  endfunction

endpackage

// File: rtl/get_volume_at_limit_if.sv
// Query bus for get_volume_at_limit.
// Signals: start/side/limit (query request), volume/done (result),
// and, when BOOK_WRITE_EN is defined, the wr_* order-table write port.
// master = requester side, slave = the query engine.
interface get_volume_at_limit_if #(
  parameter int W  = 16,
  parameter int AW = 4
);
  logic         start;
  logic         side;
  logic [W-1:0] limit;
  logic [W-1:0] volume;
  logic         done;
`ifdef BOOK_WRITE_EN
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_valid;
  logic          wr_side;
  logic [W-1:0]  wr_size;
  logic [W-1:0]  wr_limit;

  modport master (output start, side, limit, wr_en, wr_addr, wr_valid,
                         wr_side, wr_size, wr_limit,
                  input  volume, done);
  modport slave  (input  start, side, limit, wr_en, wr_addr, wr_valid,
                         wr_side, wr_size, wr_limit,
                  output volume, done);
`else
  modport master (output start, side, limit, input volume, done);
  modport slave  (input start, side, limit, output volume, done);
`endif
endinterface

// File: rtl/lob_order_table.sv
// Order table: DEPTH register entries {valid, side, size, limit},
// preloaded from DEFAULT_BOOK on synchronous reset, read combinationally
// by rd_idx. Optional write port (macro BOOK_WRITE_EN): wr_en writes
// entry[wr_addr] at the clock edge; the caller qualifies wr_en.
// Ports: clk, rst, [wr_en, wr_addr, wr_valid, wr_side, wr_size, wr_limit],
// rd_idx, rd_valid, rd_side, rd_size, rd_limit.
module lob_order_table
  import lob_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = LOB_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
`ifdef BOOK_WRITE_EN
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_valid,
  input  logic          wr_side,
  input  logic [W-1:0]  wr_size,
  input  logic [W-1:0]  wr_limit,
`endif
  input  logic [AW-1:0] rd_idx,
  output logic          rd_valid,
  output logic          rd_side,
  output logic [W-1:0]  rd_size,
  output logic [W-1:0]  rd_limit
);

  logic [DEPTH-1:0]        valid_q;
  logic [DEPTH-1:0]        side_q;
  logic [DEPTH-1:0][W-1:0] size_q;
  logic [DEPTH-1:0][W-1:0] limit_q;

  order_entry_t dflt [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_dflt
    assign dflt[g] = default_entry(g);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= dflt[i].valid;
        side_q[i]  <= dflt[i].side;
        size_q[i]  <= W'(dflt[i].size);
        limit_q[i] <= W'(dflt[i].limit);
      end
    end
`ifdef BOOK_WRITE_EN
    else if (wr_en) begin
      valid_q[wr_addr] <= wr_valid;
      side_q[wr_addr]  <= wr_side;
      size_q[wr_addr]  <= wr_size;
      limit_q[wr_addr] <= wr_limit;
    end
`endif
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_side  = side_q[rd_idx];
  assign rd_size  = size_q[rd_idx];
  assign rd_limit = limit_q[rd_idx];

endmodule

// File: rtl/get_volume_at_limit.sv
// Order-book volume query. On start (sampled in IDLE) latches side/limit,
// scans the order table one entry per cycle, sums the size of matching
// valid orders with saturation at 2^W-1, then presents the total on volume
// with a one-cycle done pulse (done follows start by DEPTH+1 edges).
// Ports: clk, rst (sync, active-high), bus (get_volume_at_limit_if.slave).
// Macro BOOK_WRITE_EN adds a table write port, honoured only in IDLE.
module get_volume_at_limit
  import lob_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = LOB_W
) (
  input  logic                    clk,
  input  logic                    rst,
  get_volume_at_limit_if.slave    bus
);

  localparam int AW = $clog2(DEPTH);

  state_t         state, state_n;
  logic [AW-1:0]  idx, idx_n;
  logic [W-1:0]   acc, acc_n;
  logic [W-1:0]   volume_q, volume_n;
  logic           done_q, done_n;
  logic           q_side, q_side_n;
  logic [W-1:0]   q_limit, q_limit_n;

  logic           rd_valid, rd_side;
  logic [W-1:0]   rd_size, rd_limit;
  logic           match;
  logic [W:0]     sum;

  lob_order_table #(.DEPTH(DEPTH), .W(W), .AW(AW)) u_table (
    .clk      (clk),
    .rst      (rst),
`ifdef BOOK_WRITE_EN
    // Writes land at the IDLE edge, so a same-cycle start scans the new data.
    .wr_en    (bus.wr_en && (state == ST_IDLE)),
    .wr_addr  (bus.wr_addr),
    .wr_valid (bus.wr_valid),
    .wr_side  (bus.wr_side),
    .wr_size  (bus.wr_size),
    .wr_limit (bus.wr_limit),
`endif
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_side  (rd_side),
    .rd_size  (rd_size),
    .rd_limit (rd_limit)
  );

  assign match = rd_valid && (rd_side == q_side) && (rd_limit == q_limit);
  assign sum   = {1'b0, acc} + {1'b0, rd_size};

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    acc_n     = acc;
    volume_n  = volume_q;
    done_n    = 1'b0;
    q_side_n  = q_side;
    q_limit_n = q_limit;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          q_side_n  = bus.side;
          q_limit_n = bus.limit;
          acc_n     = '0;
          idx_n     = '0;
          state_n   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (match) acc_n = sum[W] ? '1 : sum[W-1:0];
        if (idx == AW'(DEPTH - 1)) state_n = ST_FINISH;
        else                       idx_n   = idx + 1'b1;
      end
      ST_FINISH: begin
        volume_n = acc;
        done_n   = 1'b1;
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      acc      <= '0;
      volume_q <= '0;
      done_q   <= 1'b0;
      q_side   <= 1'b0;
      q_limit  <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      acc      <= acc_n;
      volume_q <= volume_n;
      done_q   <= done_n;
      q_side   <= q_side_n;
      q_limit  <= q_limit_n;
    end
  end

  assign bus.volume = volume_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_get_volume_at_limit.sv
// Self-checking bench for get_volume_at_limit: table-driven queries,
// hand-written corner sequences, then randomized queries against an
// order-book model. Write-port tests build only with BOOK_WRITE_EN.
module tb_get_volume_at_limit;

  localparam int DEPTH = 16;
  localparam int W     = 16;
  localparam int AW    = 4;
  localparam int MAXV  = 65535;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  get_volume_at_limit_if #(.W(W), .AW(AW)) bus ();

  get_volume_at_limit #(.DEPTH(DEPTH), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests  = 0;
  int failed = 0;

  // Reference order book
  bit m_valid [DEPTH];
  bit m_side  [DEPTH];
  int m_size  [DEPTH];
  int m_limit [DEPTH];

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0; m_side[i] = 0; m_size[i] = 0; m_limit[i] = 0;
    end
    m_valid[0] = 1; m_side[0] = 0; m_limit[0] = 1; m_size[0] = 1;
    m_valid[1] = 1; m_side[1] = 0; m_limit[1] = 1; m_size[1] = 4;
    m_valid[2] = 1; m_side[2] = 1; m_limit[2] = 1; m_size[2] = 7;
    m_valid[3] = 1; m_side[3] = 0; m_limit[3] = 2; m_size[3] = 10;
  endfunction

  function automatic int model_vol(bit s, int lim);
    int tot = 0;
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[i] && m_side[i] == s && m_limit[i] == lim) tot += m_size[i];
    return (tot > MAXV) ? MAXV : tot;
  endfunction

  task automatic check(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

`ifdef BOOK_WRITE_EN
  bit pend_wr = 0;
  task automatic set_wr(int addr, bit v, bit s, int sz, int lim);
    bus.wr_addr  = AW'(addr);
    bus.wr_valid = v;
    bus.wr_side  = s;
    bus.wr_size  = W'(sz);
    bus.wr_limit = W'(lim);
  endtask

  task automatic do_write(int addr, bit v, bit s, int sz, int lim);
    @(negedge clk);
    set_wr(addr, v, s, sz, lim);
    bus.wr_en = 1'b1;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    m_valid[addr] = v; m_side[addr] = s; m_size[addr] = sz; m_limit[addr] = lim;
  endtask
`endif

  // Issue one query; lat = edges from start edge to done (-1 on timeout).
  task automatic run_query(input bit s, input int lim, output int vol, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.side  = s;
    bus.limit = W'(lim);
`ifdef BOOK_WRITE_EN
    if (pend_wr) bus.wr_en = 1'b1;
`endif
    @(posedge clk); #1;
    bus.start = 1'b0;
`ifdef BOOK_WRITE_EN
    bus.wr_en = 1'b0;
    pend_wr   = 0;
`endif
    bus.side  = ~s;              // latched copies must be used
    bus.limit = W'($urandom);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = c; break; end
    end
    vol = int'(bus.volume);
  endtask

  task automatic query_check(string name, bit s, int lim, int exp);
    int vol, lat;
    run_query(s, lim, vol, lat);
    check({name, "_latency"}, lat, DEPTH + 1);
    check({name, "_volume"}, vol, exp);
    @(posedge clk); #1;
    check({name, "_done_width"}, int'(bus.done), 0);
    check({name, "_volume_hold"}, int'(bus.volume), exp);
  endtask

  task automatic count_done(input int cycles, output int n, output int last_vol);
    n = 0; last_vol = -1;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin n++; last_vol = int'(bus.volume); end
    end
  endtask

  typedef struct {
    bit    side;
    int    limit;
    int    exp_vol;
    string name;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n, v;
    vecs[0] = '{0, 1, 5,  "bid_l1"};
    vecs[1] = '{1, 1, 7,  "ask_l1"};
    vecs[2] = '{0, 2, 10, "bid_l2"};
    vecs[3] = '{0, 3, 0,  "bid_l3_nomatch"};
    vecs[4] = '{0, 0, 0,  "bid_l0_zero_limit"};

    bus.start = 1'b0; bus.side = 1'b0; bus.limit = '0;
`ifdef BOOK_WRITE_EN
    bus.wr_en = 1'b0;
    set_wr(0, 0, 0, 0, 0);
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_volume", int'(bus.volume), 0);
    check("reset_done", int'(bus.done), 0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 5; i++)
      query_check(vecs[i].name, vecs[i].side, vecs[i].limit, vecs[i].exp_vol);

    // start during SCAN is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.side = 1'b0; bus.limit = 16'd1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.side = 1'b1; bus.limit = 16'd2;
    @(posedge clk); #1 bus.start = 1'b0;
    count_done(2 * DEPTH, n, v);
    check("scan_start_ignored_dones", n, 1);
    check("scan_start_ignored_volume", v, 5);

`ifdef BOOK_WRITE_EN
    // saturation through written entries
    do_write(4, 1, 0, 16'hFFF0, 9);
    do_write(5, 1, 0, 16'hFFF0, 9);
    query_check("wr_saturate", 0, 9, 16'hFFFF);
    // write coincident with start is seen by the query
    set_wr(1, 0, 0, 4, 1);
    pend_wr = 1;
    m_valid[1] = 0;
    query_check("wr_same_cycle", 0, 1, 1);
    // write during SCAN is dropped
    @(negedge clk);
    bus.start = 1'b1; bus.side = 1'b0; bus.limit = 16'd1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    set_wr(0, 0, 0, 0, 1);
    bus.wr_en = 1'b1;
    @(posedge clk); #1 bus.wr_en = 1'b0;
    count_done(2 * DEPTH, n, v);
    check("wr_in_scan_dones", n, 1);
    query_check("wr_in_scan_ignored", 0, 1, model_vol(0, 1));
`endif

    // reset mid-scan aborts the query and reloads the book
    @(negedge clk);
    bus.start = 1'b1; bus.side = 1'b1; bus.limit = 16'd1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("midscan_rst_volume", int'(bus.volume), 0);
    check("midscan_rst_done", int'(bus.done), 0);
    @(negedge clk) rst = 1'b0;
    model_reset();
    count_done(2 * DEPTH, n, v);
    check("midscan_rst_no_done", n, 0);
    query_check("after_rst", 0, 1, 5);

    // randomized queries against the model
    for (int i = 0; i < 24; i++) begin
      bit s;
      int lim;
`ifdef BOOK_WRITE_EN
      if ($urandom_range(0, 1) == 1)
        do_write($urandom_range(0, DEPTH - 1), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), $urandom_range(0, MAXV),
                 $urandom_range(0, 3));
`endif
      s   = 1'($urandom_range(0, 1));
      lim = ($urandom_range(0, 7) == 0) ? $urandom_range(0, MAXV) : $urandom_range(0, 3);
      query_check($sformatf("rand%0d", i), s, lim, model_vol(s, lim));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
